// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the bf16 sigmoid pipeline: number formats,
// segment geometry and the piecewise-linear coefficient ROM.
package sigmoid_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    // Segment geometry and fixed-point formats
    localparam int SEG_BITS = 4;
    localparam int SEGS     = 1 << SEG_BITS;
    localparam int XFRAC    = 12;              // |x| in unsigned Q3.12
    localparam int XW       = 3 + XFRAC;       // 15-bit magnitude
    localparam int YFRAC    = 16;              // sigmoid value in unsigned Q0.16
    localparam int LATENCY  = 4;

    // bf16 constants
    localparam logic [15:0] ONE  = 16'h3F80;
    localparam logic [15:0] HALF = 16'h3F00;
    localparam logic [15:0] QNAN = 16'h7FC0;
    localparam logic [15:0] ZERO = 16'h0000;

    localparam logic [7:0] EXP_BIAS  = 8'd127;
    // Exponent at which {1,mant} (1.7 fixed) already sits on the Q3.12 grid
    // without shifting: 127 + 7 - XFRAC.
    localparam logic [7:0] EXP_ALIGN = 8'(127 + 7 - XFRAC);
    // First exponent whose magnitude is >= 8.0, beyond the PWL range.
    localparam logic [7:0] EXP_SAT   = 8'd130;

    // Chord slopes of sigmoid over [k/2, (k+1)/2], unsigned Q0.16.
    localparam logic [15:0] SLOPE [SEGS] = '{
        16'd16051, 16'd14234, 16'd11340, 16'd8287,
        16'd5681,  16'd3727,  16'd2374,  16'd1485,
        16'd917,   16'd563,   16'd344,   16'd209,
        16'd127,   16'd77,    16'd47,    16'd28
    };

    // Chord intercepts, unsigned Q0.16. Several entries are nudged up by a
    // few LSBs so each segment starts no lower than its neighbour ends after
    // the product truncation; that keeps the output monotonic in x.
    localparam logic [15:0] INTERCEPT [SEGS] = '{
        16'd32768, 16'd33676, 16'd36571, 16'd41151,
        16'd46363, 16'd51248, 16'd55307, 16'd58419,
        16'd60691, 16'd62284, 16'd63379, 16'd64122,
        16'd64614, 16'd64939, 16'd65149, 16'd65291
    };

endpackage

// File: rtl/sigmoid_pipelined_bf16_pack.sv
// Combinational Q0.16 -> bf16 normalizer: leading-one detect, shift the
// leading one out, truncate the mantissa to 7 bits.
module bf16_pack
    import sigmoid_pkg::*;
(
    input  logic [15:0] q,
    output logic [15:0] bf
);

    logic [3:0] lzc;
    logic       found;
    logic [6:0] mant;

    // Count leading zeros, then align the bits below the leading one
    always_comb begin
        lzc   = 4'd0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && q[i]) begin
                lzc   = 4'(15 - i);
                found = 1'b1;
            end
        end
        mant = 7'((q << lzc) >> 8);
        if (q == 16'd0) begin
            bf = ZERO;
        end else begin
            bf = {1'b0, EXP_BIAS - {4'd0, lzc} - 8'd1, mant};
        end
    end

endmodule

// File: rtl/sigmoid_pipelined.sv
// Streaming bf16 sigmoid, one sample per clock, fixed 4-cycle latency.
// PWL evaluation on |x| with sigmoid(-x) = 1 - sigmoid(x); special inputs
// (NaN, inf, |x| >= 8, zero/denormal) bypass the arithmetic in flight.
module sigmoid_pipelined
    import sigmoid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] data_in,
    output logic        valid_out,
    output logic [15:0] data_out
);

    function automatic logic [XW-1:0] to_q312(input logic [7:0] e, input logic [6:0] m);
        logic [XW-1:0] sig;
        sig = {7'd0, 1'b1, m};
        if (e >= EXP_ALIGN) begin
            return sig << (e - EXP_ALIGN);
        end
        return sig >> (EXP_ALIGN - e);
    endfunction

    function automatic logic [15:0] sat_q016(input logic [19:0] v);
        if (v > 20'h0FFFF) begin
            return 16'hFFFF;
        end
        if (v < 20'h08000) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    function automatic logic [15:0] reflect_q016(input logic [15:0] f);
        logic signed [17:0] r;
        r = $signed(18'(1 << YFRAC)) - $signed({2'b00, f});
        if (r < 18'sd0) begin
            return 16'h0000;
        end
        if (r > 18'sh0FFFF) begin
            return 16'hFFFF;
        end
        return r[15:0];
    endfunction

    // valid tag: bit k marks the sample held in stage k+1
    logic [LATENCY-1:0] vld_sr;

    bf16_t              x_s1;
    logic               special_s1;
    logic [15:0]        spec_val_s1;
    logic [XW-1:0]      xq_s1;

    logic               sign_p1;
    logic               special_p1;
    logic [15:0]        spec_val_p1;
    logic [XW-1:0]      xq_p1;

    logic [SEG_BITS-1:0] idx_s2;
    logic [30:0]         prod_s2;

    logic               sign_p2;
    logic               special_p2;
    logic [15:0]        spec_val_p2;
    logic [15:0]        icpt_p2;
    logic [30:0]        prod_p2;

    logic [19:0]        sum_s3;
    logic [15:0]        f_s3;

    logic               special_p3;
    logic [15:0]        spec_val_p3;
    logic [15:0]        q_p3;

    logic [15:0]        packed_s4;

    // ---- S1: unpack / classify ----
    // Special inputs resolve to their final bf16 code here; the rest become Q3.12
    always_comb begin
        x_s1        = bf16_t'(data_in);
        special_s1  = 1'b0;
        spec_val_s1 = ZERO;
        xq_s1       = '0;
        if (x_s1.exp == 8'hFF && x_s1.mant != 7'd0) begin
            special_s1  = 1'b1;
            spec_val_s1 = QNAN;
        end else if (x_s1.exp >= EXP_SAT) begin
            special_s1  = 1'b1;
            spec_val_s1 = x_s1.sign ? ZERO : ONE;
        end else if (x_s1.exp == 8'd0) begin
            special_s1  = 1'b1;
            spec_val_s1 = HALF;
        end else begin
            xq_s1 = to_q312(x_s1.exp, x_s1.mant);
        end
    end

    // S1 data register
    always_ff @(posedge clk) begin
        sign_p1     <= x_s1.sign;
        special_p1  <= special_s1;
        spec_val_p1 <= spec_val_s1;
        xq_p1       <= xq_s1;
    end

    // ---- S2: segment lookup and slope product ----
    // Top four magnitude bits pick one of 16 half-unit segments over [0,8)
    always_comb begin
        idx_s2  = xq_p1[XW-1 -: SEG_BITS];
        prod_s2 = 31'(SLOPE[idx_s2]) * 31'(xq_p1);
    end

    // S2 data register
    always_ff @(posedge clk) begin
        sign_p2     <= sign_p1;
        special_p2  <= special_p1;
        spec_val_p2 <= spec_val_p1;
        icpt_p2     <= INTERCEPT[idx_s2];
        prod_p2     <= prod_s2;
    end

    // ---- S3: evaluate, saturate, mirror for negative inputs ----
    // Positive half lands in [0.5, 1); the mirror gives 1 - f for x < 0
    always_comb begin
        sum_s3 = 20'(icpt_p2) + 20'(prod_p2 >> XFRAC);
        f_s3   = sat_q016(sum_s3);
        if (sign_p2) begin
            f_s3 = reflect_q016(f_s3);
        end
    end

    // S3 data register
    always_ff @(posedge clk) begin
        special_p3  <= special_p2;
        spec_val_p3 <= spec_val_p2;
        q_p3        <= f_s3;
    end

    // ---- S4: pack Q0.16 to bf16 ----
    bf16_pack u_pack (
        .q  (q_p3),
        .bf (packed_s4)
    );

    // Valid shift register and output; data_out only updates on a valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr   <= '0;
            data_out <= ZERO;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], valid_in};
            if (vld_sr[LATENCY-2]) begin
                data_out <= special_p3 ? spec_val_p3 : packed_s4;
            end
        end
    end

    assign valid_out = vld_sr[LATENCY-1];

endmodule

// File: tb/tb_sigmoid_pipelined.sv
// Self-checking bench for sigmoid_pipelined: directed vectors, full sweep of
// [-8,8], randomized gapped stream and mid-stream reset, all scored against a
// real-valued sigmoid model and a 4-deep delay queue.
module tb_sigmoid_pipelined;

    localparam int  LAT = 4;
    localparam real TOL = 1.0 / 128.0;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [15:0] data_out;

    always #5 clk = ~clk;

    sigmoid_pipelined dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } ent_t;

    ent_t        hist[$];
    int          checks = 0;
    int          errors = 0;
    bit          have_last;
    logic [15:0] last_x;
    bit          mono_en;
    real         prev_y;
    logic [15:0] prev_bits;

    function automatic real bf2real(input logic [15:0] b);
        real mag;
        int  e;
        if (b[14:7] == 8'd0) return 0.0;
        mag = 1.0 + real'(b[6:0]) / 128.0;
        e   = int'(b[14:7]) - 127;
        while (e > 0) begin mag = mag * 2.0; e--; end
        while (e < 0) begin mag = mag / 2.0; e++; end
        return b[15] ? -mag : mag;
    endfunction

    function automatic real sigmoid(input real x);
        return 1.0 / (1.0 + $exp(-x));
    endfunction

    // Output acceptable for input x under the behavioural rules
    function automatic bit out_ok(input logic [15:0] x, input logic [15:0] y);
        real xr, err;
        if ($isunknown(y)) return 1'b0;
        if (x[14:7] == 8'hFF && x[6:0] != 7'd0) return (y == 16'h7FC0);
        if (y[15] != 1'b0 || y > 16'h3F80) return 1'b0;
        if (x[14:7] == 8'hFF) xr = x[15] ? -100.0 : 100.0;
        else xr = bf2real(x);
        if (xr >= 8.0)  return (y == 16'h3F80);
        if (xr <= -8.0) return (y == 16'h0000);
        err = bf2real(y) - sigmoid(xr);
        if (err < 0.0) err = -err;
        return (err <= TOL);
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag, input logic [15:0] x, input logic [15:0] y);
        bit ok;
        ok = out_ok(x, y);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h expected=sigmoid(%h) within 2^-7", tag, y, x);
        end
    endtask

    task automatic check_mono(input logic [15:0] y);
        bit ok;
        ok = (bf2real(y) >= prev_y);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL monotonic observed=%h expected>=%h", y, prev_bits);
        end
        prev_y    = bf2real(y);
        prev_bits = y;
    endtask

    // One clock: drive, advance, score the sample that entered LAT cycles ago
    task automatic step(input bit v, input logic [15:0] d);
        ent_t e, o;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
        e.v = v;
        e.d = d;
        hist.push_back(e);
        if (hist.size() >= LAT) begin
            o = hist.pop_front();
            check_eq("valid_out", 16'(valid_out), 16'(o.v));
            if (o.v) begin
                check_model("data_out", o.d, data_out);
                if (mono_en) check_mono(data_out);
                have_last = 1'b1;
                last_x    = o.d;
            end else if (!have_last) begin
                check_eq("data_out_idle", data_out, 16'h0000);
            end else begin
                check_model("data_out_hold", last_x, data_out);
            end
        end
    endtask

    task automatic do_reset(input int n);
        ent_t z;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 16'h0000;
        repeat (n) @(posedge clk);
        #1;
        check_eq("rst_valid_out", 16'(valid_out), 16'h0000);
        check_eq("rst_data_out", data_out, 16'h0000);
        rst = 1'b0;
        hist.delete();
        z.v = 1'b0;
        z.d = 16'h0000;
        repeat (LAT - 1) hist.push_back(z);
        have_last = 1'b0;
    endtask

    // One sample followed by idle cycles; compare the result to a known code
    task automatic directed(input string tag, input logic [15:0] x,
                            input logic [15:0] y, input int tol);
        int diff;
        bit ok;
        step(1'b1, x);
        repeat (LAT - 1) step(1'b0, 16'($urandom));
        diff = int'(data_out) - int'(y);
        ok   = (valid_out === 1'b1) && (diff >= -tol) && (diff <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, data_out, y);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mono_en   = 1'b0;
        prev_y    = -1.0;
        prev_bits = 16'h0000;
        have_last = 1'b0;
        last_x    = 16'h0000;
        do_reset(5);

        directed("latency_zero", 16'h0000, 16'h3F00, 0);
        directed("pos_one",      16'h3F80, 16'h3F3B, 1);
        directed("neg_one",      16'hBF80, 16'h3E89, 1);
        directed("pos_two",      16'h4000, 16'h3F61, 1);
        directed("pos_ten",      16'h4120, 16'h3F80, 0);
        directed("neg_ten",      16'hC120, 16'h0000, 0);
        directed("pos_inf",      16'h7F80, 16'h3F80, 0);
        directed("neg_inf",      16'hFF80, 16'h0000, 0);
        directed("nan",          16'h7FC0, 16'h7FC0, 0);
        directed("denormal",     16'h0001, 16'h3F00, 0);
        directed("pos_eight",    16'h4100, 16'h3F80, 0);
        directed("neg_eight",    16'hC100, 16'h0000, 0);

        // Sweep every bf16 in [-8,8] in increasing x order, back-to-back
        mono_en   = 1'b1;
        prev_y    = -1.0;
        prev_bits = 16'h0000;
        for (int k = 'hC100; k >= 'h8000; k--) step(1'b1, 16'(k));
        for (int k = 'h0000; k <= 'h4100; k++) step(1'b1, 16'(k));
        repeat (LAT - 1) step(1'b0, 16'($urandom));
        mono_en = 1'b0;

        // Random stream with gaps
        for (int n = 0; n < 1500; n++) begin
            bit          v;
            logic [15:0] d;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) d = 16'($urandom);
            else d = {1'($urandom), 8'($urandom_range(110, 133)), 7'($urandom)};
            step(v, d);
        end

        // Reset while three samples are in flight
        repeat (2) step(1'b0, 16'($urandom));
        step(1'b1, 16'h3F80);
        step(1'b1, 16'hBF80);
        step(1'b1, 16'h4000);
        do_reset(1);
        repeat (6) step(1'b0, 16'($urandom));
        directed("post_reset", 16'h3F80, 16'h3F3B, 1);
        repeat (3) step(1'b0, 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
